param_ram: RTL
==============

PARAM_RAM -- requirements
Module: param_ram

Interface
REQ-001 Parameter DATA_W, default 32: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 7: address width; depth SHALL be DEPTH = 2**ADDR_W words.
REQ-003 Parameter OUT_REG, default 0: 0 gives read latency 1; 1 adds an output register, giving latency 2.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 en  input  1  access enable; ignored while busy=1.
REQ-008 we  input  1  write qualifier for an accepted access.
REQ-009 be  input  DATA_W/8  byte write enables; bit k covers din[8k+7:8k].
REQ-010 addr  input  ADDR_W  word address.
REQ-011 din  input  DATA_W  write data.
REQ-012 clr_start  input  1  single-cycle request to zero the whole array.
REQ-013 dout  output  DATA_W  read data.
REQ-014 dout_valid  output  1  high for exactly one cycle when dout carries the result of an accepted access.
REQ-015 busy  output  1  high while the clear engine owns the array.

Function
REQ-016 Access accepted: en=1 and busy=0 at a rising edge.
REQ-017 Accepted write (we=1): only bytes with be[k]=1 SHALL update; be=0 SHALL leave the word unchanged.
REQ-018 Every accepted access, read or write, SHALL return the word at addr with read-first semantics, i.e. the pre-write contents.
REQ-019 OUT_REG=0: dout/dout_valid SHALL update on the edge after acceptance. OUT_REG=1: they SHALL update one further edge later.
REQ-020 Back-to-back accesses SHALL be accepted every cycle; throughput is one access per cycle at both latencies.
REQ-021 dout SHALL hold its last value when no result is delivered; dout_valid SHALL then be 0.
REQ-022 FSM states: IDLE and CLEAR.
  - IDLE -> CLEAR on rst, or on clr_start=1 while in IDLE.
  - CLEAR -> IDLE after the write to address DEPTH-1.
REQ-023 CLEAR operation:
  - An internal ADDR_W counter starts at 0 and writes zero to one word per cycle.
  - The clear therefore takes exactly DEPTH cycles.
  - busy=1 throughout the clear.
REQ-024 busy SHALL fall on the edge that completes the DEPTH-1 write; the next cycle accepts accesses.
REQ-025 clr_start while in CLEAR SHALL be ignored; the current clear does not restart.
REQ-026 An accepted access in the same cycle as clr_start SHALL complete first; the clear begins on the next edge.
REQ-027 Results already in the OUT_REG pipeline when CLEAR begins SHALL still be delivered with dout_valid.
REQ-028 rst asserted mid-clear SHALL restart the clear from address 0.

Reset
REQ-029 While rst=1:
  - dout=0, dout_valid=0, the output pipeline is flushed, busy=1, and the clear counter is held at 0.
  - On the first edge with rst=0 the clear SHALL write address 0.
REQ-030 After the reset-triggered clear completes, every word SHALL read 0. There is no other initial-content mechanism.

Verification
REQ-031 Reset and clear, DEPTH=128:
  - Stimulus: rst high 2 cycles, then low.
  - Response: busy=1 for exactly 128 cycles after rst falls, and no access is accepted during them.
  - Then a read of addr 0x7F returns 0.
REQ-032 Byte enables:
  - Stimulus: write 0x7A6F6E65 (ASCII "zone") to addr 10 with be=4'b1111, then write 0xFFFFFFFF with be=4'b0101.
  - Response: the read of addr 10 returns 0x7AFF6EFF.
REQ-033 Read-first:
  - Stimulus: addr 12 holds 0x30383030; write 0x30393030 to addr 12.
  - Response: that access returns 0x30383030, and a following read returns 0x30393030.
REQ-034 Latency and throughput:
  - Stimulus: OUT_REG=0 and OUT_REG=1 builds, reads of addrs 0..3 on consecutive cycles.
  - Response: dout_valid is high for 4 consecutive cycles, starting at edge +1 and edge +2 from the first access respectively.
  - Data arrives in order.
REQ-035 Clear collision:
  - Stimulus: OUT_REG=1, read addr 5 (value 0x11) in the same cycle as clr_start.
  - Response: 0x11 is delivered with dout_valid.
  - busy rises on the next edge, and clr_start pulses during CLEAR leave the 128-cycle duration unchanged.
REQ-036 Mid-clear reset:
  - Stimulus: rst asserted at clear cycle 60 for 1 cycle.
  - Response: busy stays high for 128 cycles after rst falls, and all words then read 0.

Source files
------------

// File: rtl/param_ram.sv
// Single-port RAM with byte write enables, read-first access semantics,
// an optional output register, and a hardware clear engine that zeroes the array.
module param_ram #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 7,
   parameter int unsigned OUT_REG = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                we,
   input  logic [DATA_W/8-1:0] be,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   din,
   input  logic                clr_start,
   output logic [DATA_W-1:0]   dout,
   output logic                dout_valid,
   output logic                busy
);

   localparam int unsigned NB    = DATA_W / 8;
   localparam int unsigned DEPTH = 2 ** ADDR_W;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t              state, state_n;
   logic [ADDR_W-1:0]   cnt, cnt_n;
   logic                clr_we;
   logic                accept;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [DATA_W-1:0]   d1;
   logic                v1;

   // rst forces busy immediately so no access slips in during the reset cycle itself
   assign busy   = rst | (state == CLEAR);
   assign accept = en & ~busy;
   assign clr_we = (state == CLEAR) & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         IDLE: begin
            if (clr_start) begin
               state_n = CLEAR;
               cnt_n   = '0;
            end
         end
         CLEAR: begin
            cnt_n = cnt + 1'b1;
            if (cnt == '1) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[cnt] <= '0;
      end else if (accept && we) begin
         for (int unsigned k = 0; k < NB; k++) begin
            if (be[k]) mem[addr][8*k +: 8] <= din[8*k +: 8];
         end
      end
   end

   // Read-first: the nonblocking read captures the pre-write word
   always_ff @(posedge clk) begin
      if (rst) begin
         d1 <= '0;
         v1 <= 1'b0;
      end else begin
         v1 <= accept;
         if (accept) d1 <= mem[addr];
      end
   end

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic [DATA_W-1:0] d2;
         logic              v2;
         always_ff @(posedge clk) begin
            if (rst) begin
               d2 <= '0;
               v2 <= 1'b0;
            end else begin
               v2 <= v1;
               if (v1) d2 <= d1;
            end
         end
         assign dout       = d2;
         assign dout_valid = v2;
      end else begin : g_noreg
         assign dout       = d1;
         assign dout_valid = v1;
      end
   endgenerate

endmodule
